// File: rtl/reg_trace_uart_pkg.sv
// Shared FSM encodings and helpers for the register trace UART.
// REG_TRACE_SYNC_EN adds a sync byte in front of every traced word.
package reg_trace_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

`ifdef REG_TRACE_SYNC_EN
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`endif

  // Bytes on the wire per traced word, including the optional sync byte.
  function automatic int bytes_per_word(input int data_w);
`ifdef REG_TRACE_SYNC_EN
    return data_w / 8 + 1;
`else
    return data_w / 8;
`endif
  endfunction

  // Counter width that stays at least 1 bit for degenerate ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_trace_uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout is valid whenever empty=0.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_trace_uart.sv
// Watches a debug register, queues every new value and streams it out as 8N1 UART,
// LSB byte first. REG_TRACE_SYNC_EN prefixes each word with a sync byte.
module reg_trace_uart
  import reg_trace_uart_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] watch_val,
  input  logic              watch_en,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int BW     = idx_width(NBYTES);
  localparam int CW     = idx_width(CLKS_PER_BIT);
  localparam int FAW    = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  uart_state_e       r_state, w_state_nxt;
  logic [CW-1:0]     r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [BW-1:0]     r_byte_idx, w_byte_idx_nxt;
  logic [DATA_W-1:0] r_word_sr, w_word_sr_nxt;
  logic [DATA_W-1:0] r_prev_val;
  logic              r_primed;
  logic              r_overflow;
  logic              r_tx;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [FAW:0]      w_count;
  logic              w_bit_end;
  logic              w_tx;
  logic [7:0]        w_cur_byte;
  logic              w_adv_shift;

  // The first enabled sample always counts as a change so the initial value is traced.
  assign w_push = watch_en && (!r_primed || (watch_val != r_prev_val));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (watch_val),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef REG_TRACE_SYNC_EN
  // Byte slot 0 carries the sync marker; the payload shifts only after real data bytes.
  assign w_cur_byte  = (r_byte_idx == '0) ? SYNC_BYTE : r_word_sr[7:0];
  assign w_adv_shift = (r_byte_idx != '0);
`else
  assign w_cur_byte  = r_word_sr[7:0];
  assign w_adv_shift = 1'b1;
`endif

  assign w_bit_end = (r_clk_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = r_clk_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_word_sr_nxt  = r_word_sr;
    w_pop          = 1'b0;
    w_tx           = 1'b1;

    if (r_state != S_IDLE) w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_word_sr_nxt  = w_head;
          w_byte_idx_nxt = '0;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = w_cur_byte[r_bit_idx];
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte_idx != LAST_BYTE) begin
            w_byte_idx_nxt = r_byte_idx + 1'b1;
            if (w_adv_shift) w_word_sr_nxt = r_word_sr >> 8;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered, so the line follows the FSM state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_word_sr  <= '0;
      r_tx       <= 1'b1;
      r_prev_val <= '0;
      r_primed   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word_sr  <= w_word_sr_nxt;
      r_tx       <= w_tx;
      if (watch_en) begin
        r_prev_val <= watch_val;
        r_primed   <= 1'b1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign tx        = r_tx;
  assign busy      = (r_state != S_IDLE) || (w_count != '0);
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_reg_trace_uart.sv
// Directed bench for reg_trace_uart at CLKS_PER_BIT=4; a UART monitor decodes tx bytes.
// Define REG_TRACE_SYNC_EN for both bench and RTL to exercise the sync-byte build.
module tb_reg_trace_uart;

  localparam int CPB = 4;
`ifdef REG_TRACE_SYNC_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int WORD_CYC = 10 * NB * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] watch_val = '0;
  logic        watch_en = 1'b0;
  logic        tx, busy, fifo_full, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_stop_err = 0;
  logic [7:0] rxq[$];
  int         rxs[$];
  logic [7:0] expq[$];

  reg_trace_uart #(
    .DATA_W       (32),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .watch_val (watch_val),
    .watch_en  (watch_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART receiver: detects the start bit at a falling edge, samples one point per bit.
  initial begin
    bit         act = 1'b0;
    int         cnt = 0;
    int         t0 = 0;
    logic [7:0] sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
          t0  = cyc;
        end
      end else begin
        cnt++;
        if (cnt % CPB == 0 && cnt <= 8 * CPB) sh = {tx, sh[7:1]};
        if (cnt == 9 * CPB) begin
          if (tx !== 1'b1) rx_stop_err++;
          rxq.push_back(sh);
          rxs.push_back(t0);
          act = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_word(input logic [31:0] w);
`ifdef REG_TRACE_SYNC_EN
    expq.push_back(8'hA5);
`endif
    for (int i = 0; i < 4; i++) expq.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("rx_timeout", 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    fall = cyc;
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_count"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
  endtask

  task automatic clear_q();
    rxq.delete();
    rxs.delete();
    expq.delete();
  endtask

  initial begin
    int  chg;
    int  fall;
    bit  idle_ok;

    // Reset held for two edges, then a long idle with sampling disabled.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_quiet", 32'(idle_ok), 32'd1);
    chk("idle_ovf", 32'(overflow), 32'd0);

    // First enabled sample of 0 is pushed because nothing was primed yet.
    watch_val = 32'h0;
    watch_en  = 1'b1;
    @(negedge clk);
    chg = cyc;
    chk("first_busy", 32'(busy), 32'd1);
    wait_idle(WORD_CYC + 50, fall);
    chk("first_dur", 32'(fall - chg), 32'(WORD_CYC + 1));
    wait_bytes(NB, 20);
    exp_word(32'h0);
    cmp_bytes("first");
    if (rxs.size() > 0) chk("first_lat", 32'(rxs[0] - chg), 32'd2);
    clear_q();

    // Two back-to-back changes: one IDLE cycle separates the words.
    watch_val = 32'h0000_0037;
    @(negedge clk);
    chg = cyc;
    watch_val = 32'h0000_0064;
    wait_bytes(2 * NB, 2 * WORD_CYC + 100);
    exp_word(32'h0000_0037);
    exp_word(32'h0000_0064);
    cmp_bytes("chg");
    if (rxs.size() > NB) begin
      chk("chg_lat", 32'(rxs[0] - chg), 32'd2);
      chk("chg_gap", 32'(rxs[NB] - chg), 32'(2 + WORD_CYC + 1));
    end
    wait_idle(200, fall);
    clear_q();

    // Six changes on consecutive cycles from idle: one popped, four queued, one dropped.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("ovf_full_pre", 32'(fifo_full), 32'd1);
        chk("ovf_flag_pre", 32'(overflow), 32'd0);
      end
      watch_val = 32'h1111_1111 * k;
    end
    @(negedge clk);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 1; k <= 5; k++) exp_word(32'h1111_1111 * k);
    wait_bytes(5 * NB, 5 * (WORD_CYC + 1) + 100);
    wait_idle(200, fall);
    repeat (50) @(negedge clk);
    cmp_bytes("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_full_post", 32'(fifo_full), 32'd0);
    clear_q();

    // Reset during DATA bit 3 of the first byte aborts the frame.
    watch_val = 32'h7777_7777;
    @(negedge clk);
    chg = cyc;
    while (cyc < chg + 17) @(negedge clk);
    rst = 1'b1;
    watch_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_rx", 32'(rxq.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    watch_val = 32'hDEAD_BEEF;
    watch_en  = 1'b1;
    wait_bytes(NB, WORD_CYC + 50);
    wait_idle(100, fall);
    repeat (20) @(negedge clk);
    exp_word(32'hDEAD_BEEF);
    cmp_bytes("post_rst");
    clear_q();

`ifdef REG_TRACE_SYNC_EN
    // Sync-byte build: A5 then the word LSB first, five frames per word.
    watch_val = 32'h1234_5678;
    @(negedge clk);
    chg = cyc;
    wait_idle(WORD_CYC + 50, fall);
    chk("sync_dur", 32'(fall - chg), 32'(WORD_CYC + 1));
    wait_bytes(NB, 20);
    exp_word(32'h1234_5678);
    cmp_bytes("sync");
    clear_q();
`endif

    chk("stop_bits", 32'(rx_stop_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
